// File: rtl/subleq_sequencer.sv
// Multi-cycle control FSM for the SUBLEQ core: fetch, operand read and write-back
// against a single-port memory with 1-cycle read latency.
//
// state | meaning
// IDLE  | waiting for start after reset
// FA    | issue read of word A at pc (instruction boundary, pause point)
// FB    | latch A, issue read of word B at pc+1
// FC    | latch B, issue read of word C at pc+2
// RA    | latch C, issue read of mem[A]
// RB    | latch mem[A], issue read of mem[B]
// WB    | write mem[B] - mem[A], branch or halt
// HALT  | stopped on a taken branch to a negative target, waits for start
module subleq_sequencer #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic [63:0] mem_rdata,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic [63:0] pc,
    output logic        busy,
    output logic        halted,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_WB, S_HALT
    } state_t;

    state_t      state, state_nx;
    logic [63:0] pc_nx;
    logic [63:0] a, a_nx;
    logic [63:0] b, b_nx;
    logic [63:0] c, c_nx;
    logic [63:0] va, va_nx;
    logic [31:0] cnt_nx;
    logic [63:0] diff;
    logic        leq;
    logic        we_int;

    assign diff   = mem_rdata - va;
    assign leq    = diff[63] | (diff == 64'd0);
    // A reset in the WB cycle must not commit the write.
    assign mem_we = we_int & ~rst;
    assign halted = (state == S_HALT);
    assign busy   = (state != S_IDLE) && (state != S_HALT);

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        a_nx      = a;
        b_nx      = b;
        c_nx      = c;
        va_nx     = va;
        cnt_nx    = instr_count;
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        we_int    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_nx    = RESET_PC;
                    cnt_nx   = 32'd0;
                    state_nx = S_FA;
                end
            end
            S_FA: begin
                if (!pause) begin
                    mem_addr = pc;
                    mem_re   = 1'b1;
                    state_nx = S_FB;
                end
            end
            S_FB: begin
                mem_addr = pc + 64'd1;
                mem_re   = 1'b1;
                a_nx     = mem_rdata;
                state_nx = S_FC;
            end
            S_FC: begin
                mem_addr = pc + 64'd2;
                mem_re   = 1'b1;
                b_nx     = mem_rdata;
                state_nx = S_RA;
            end
            S_RA: begin
                mem_addr = a;
                mem_re   = 1'b1;
                c_nx     = mem_rdata;
                state_nx = S_RB;
            end
            S_RB: begin
                mem_addr = b;
                mem_re   = 1'b1;
                va_nx    = mem_rdata;
                state_nx = S_WB;
            end
            S_WB: begin
                mem_addr  = b;
                mem_wdata = diff;
                we_int    = 1'b1;
                if (instr_count != 32'hFFFF_FFFF) cnt_nx = instr_count + 32'd1;
                if (leq && c[63]) begin
                    state_nx = S_HALT;
                end else if (leq) begin
                    pc_nx    = c;
                    state_nx = S_FA;
                end else begin
                    pc_nx    = pc + 64'd3;
                    state_nx = S_FA;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            a           <= 64'd0;
            b           <= 64'd0;
            c           <= 64'd0;
            va          <= 64'd0;
            instr_count <= 32'd0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            a           <= a_nx;
            b           <= b_nx;
            c           <= c_nx;
            va          <= va_nx;
            instr_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: behavioural 1-cycle-latency memory plus a write
// scoreboard, with directed programs for branch, no-branch, halt, wrap, reset and pause.
module tb_subleq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pause;
    logic [63:0] mem_rdata;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [63:0] pc;
    logic        busy;
    logic        halted;
    logic [31:0] instr_count;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] mem[0:1023];
    int          n_vec = 0;
    int          n_err = 0;

    subleq_sequencer #(.RESET_PC(64'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every committed write must match the next expected one.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", 64'(mem_we), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_val("wr_addr", mem_addr, e.addr);
                check_val("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load_prog(input logic [63:0] w0, input logic [63:0] w1, input logic [63:0] w2,
                             input logic [63:0] m5, input logic [63:0] m6);
        for (int i = 0; i < 16; i++) mem[i] = 64'd0;
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[5] = m5;
        mem[6] = m6;
    endtask

    task automatic push_wr(input logic [63:0] addr, input logic [63:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pause     = 1'b0;
        mem_rdata = 64'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 64'd0;

        // Reset state
        step();
        step();
        check_val("rst_addr", mem_addr, 64'd0);
        check_val("rst_wdata", mem_wdata, 64'd0);
        check_val("rst_we", 64'(mem_we), 64'd0);
        check_val("rst_re", 64'(mem_re), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_halted", 64'(halted), 64'd0);
        check_val("rst_pc", pc, 64'd0);
        check_val("rst_cnt", 64'(instr_count), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("idle_re", 64'(mem_re), 64'd0);
        end

        // start and rst together: rst wins
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        check_val("rst_start_busy", 64'(busy), 64'd0);

        // No branch, with a start pulse during FB that must be ignored
        load_prog(64'd5, 64'd6, 64'd9, 64'd3, 64'd10);
        push_wr(64'd6, 64'd7);
        pulse_start();
        check_val("nb_fa_re", 64'(mem_re), 64'd1);
        check_val("nb_fa_addr", mem_addr, 64'd0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_val("nb_we", 64'(mem_we), 64'd1);
        check_val("nb_addr", mem_addr, 64'd6);
        check_val("nb_wdata", mem_wdata, 64'd7);
        step();
        check_val("nb_pc", pc, 64'd3);
        check_val("nb_cnt", 64'(instr_count), 64'd1);
        check_val("nb_busy", 64'(busy), 64'd1);
        check_val("nb_mem6", mem[6], 64'd7);
        do_reset();

        // Branch taken (result zero)
        load_prog(64'd5, 64'd6, 64'd9, 64'd10, 64'd10);
        push_wr(64'd6, 64'd0);
        pulse_start();
        repeat (6) step();
        check_val("br_pc", pc, 64'd9);
        check_val("br_cnt", 64'(instr_count), 64'd1);
        do_reset();

        // Halt on negative target, then restart
        load_prog(64'd5, 64'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'd1);
        push_wr(64'd6, 64'hFFFF_FFFF_FFFF_FFFD);
        pulse_start();
        repeat (6) step();
        check_val("h_halted", 64'(halted), 64'd1);
        check_val("h_busy", 64'(busy), 64'd0);
        check_val("h_pc", pc, 64'd0);
        check_val("h_cnt", 64'(instr_count), 64'd1);
        check_val("h_mem6", mem[6], 64'hFFFF_FFFF_FFFF_FFFD);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("h_re", 64'(mem_re), 64'd0);
            check_val("h_we", 64'(mem_we), 64'd0);
        end
        push_wr(64'd6, 64'hFFFF_FFFF_FFFF_FFF9);
        pulse_start();
        check_val("hr_pc", pc, 64'd0);
        check_val("hr_cnt", 64'(instr_count), 64'd0);
        check_val("hr_halted", 64'(halted), 64'd0);
        check_val("hr_re", 64'(mem_re), 64'd1);
        repeat (6) step();
        check_val("hr_halted2", 64'(halted), 64'd1);
        check_val("hr_cnt2", 64'(instr_count), 64'd1);
        do_reset();

        // Wrap: positive minus into large negative overflows to positive
        load_prog(64'd5, 64'd6, 64'd9, 64'd1, 64'h8000_0000_0000_0000);
        push_wr(64'd6, 64'h7FFF_FFFF_FFFF_FFFF);
        pulse_start();
        repeat (6) step();
        check_val("wr_pc", pc, 64'd3);
        do_reset();

        // Reset in WB: no write committed
        load_prog(64'd5, 64'd6, 64'd9, 64'd3, 64'd10);
        pulse_start();
        repeat (5) step();
        rst = 1'b1;
        #1;
        check_val("rwb_we", 64'(mem_we), 64'd0);
        step();
        rst = 1'b0;
        check_val("rwb_busy", 64'(busy), 64'd0);
        check_val("rwb_halted", 64'(halted), 64'd0);
        check_val("rwb_re", 64'(mem_re), 64'd0);
        check_val("rwb_mem6", mem[6], 64'd10);

        // Pause held at FA
        load_prog(64'd5, 64'd6, 64'd9, 64'd3, 64'd10);
        pause = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            check_val("p_re", 64'(mem_re), 64'd0);
            check_val("p_busy", 64'(busy), 64'd1);
            step();
        end
        pause = 1'b0;
        #1;
        check_val("p_resume_re", 64'(mem_re), 64'd1);
        check_val("p_resume_addr", mem_addr, 64'd0);
        push_wr(64'd6, 64'd7);
        step();
        check_val("p_fb_addr", mem_addr, 64'd1);
        repeat (5) step();
        check_val("p_pc", pc, 64'd3);
        do_reset();

        check_val("wr_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/subleq_sequencer.md
# subleq_sequencer

Multi-cycle control FSM for the SUBLEQ core. It sequences the single-port, 64-bit, 1-cycle-read-latency program/data memory (`memory_bram`) through fetch, operand read and write-back for each instruction `mem[B] = mem[B] - mem[A]; if result <= 0 then PC = C else PC = PC + 3`. It sits between the top-level run control (start/pause/status) and the memory's address, data, write-enable and read-enable ports.

## Interface
- `RESET_PC`, default 0: PC loaded on reset and on each start.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse; begins execution when in IDLE or HALT, ignored otherwise.
- `pause`  in  1: holds the FSM at the instruction boundary (FA) while high.
- `mem_rdata`  in  64: memory read data, valid 1 cycle after the address is issued.
- `mem_addr`  out  64: memory address. Memory uses only the low 10 bits; the sequencer always drives the full 64 bits.
- `mem_wdata`  out  64: write data.
- `mem_we`  out  1: write enable.
- `mem_re`  out  1: read enable.
- `pc`  out  64: current program counter.
- `busy`  out  1: high in FA through WB.
- `halted`  out  1: high in HALT.
- `instr_count`  out  32: instructions completed since the last start; saturates at 0xFFFFFFFF.

## Operation
- States: IDLE, FA, FB, FC, RA, RB, WB, HALT.
- Memory outputs are combinational from the state and internal registers. `mem_we` is gated by `!rst`.
- IDLE or HALT, on `start`: `pc <= RESET_PC`, `instr_count <= 0`, `halted <= 0`, go to FA.
- FA: if `pause`, stay in FA with `mem_re = 0`. Otherwise `mem_addr = pc`, `mem_re = 1`, go to FB.
- FB: `mem_addr = pc+1`, `mem_re = 1`, `a <= mem_rdata`; go to FC.
- FC: `mem_addr = pc+2`, `mem_re = 1`, `b <= mem_rdata`; go to RA.
- RA: `mem_addr = a`, `mem_re = 1`, `c <= mem_rdata`; go to RB.
- RB: `mem_addr = b`, `mem_re = 1`, `va <= mem_rdata`; go to WB.
- WB: `mem_rdata` holds `mem[b]`.
  - Drive `mem_addr = b`, `mem_wdata = mem_rdata - va`, `mem_we = 1`.
  - Increment `instr_count` (saturating).
  - Compute `leq = diff[63] | (diff == 0)`.
  - If `leq` and `c[63] == 1`: go to HALT; `pc` keeps the current instruction address.
  - Else if `leq`: `pc <= c`, go to FA.
  - Else: `pc <= pc + 3`, go to FA.
- HALT: no memory access; `halted = 1` until `start`.
- Arithmetic is 64-bit two's complement with modulo-2^64 wrap. This applies to the subtraction and to `pc+1`, `pc+2`, `pc+3`; no overflow flag.
- Self-modifying code: the write in WB lands before any later fetch, so the next instruction sees the updated memory.
- `a == b`: result is 0, so the branch is always taken.

## Timing
- Reset values: state IDLE, `pc = RESET_PC`, `a`/`b`/`c`/`va` = 0, `mem_addr = 0`, `mem_wdata = 0`, `mem_we = 0`, `mem_re = 0`, `busy = 0`, `halted = 0`, `instr_count = 0`.
- Latency: 6 cycles per instruction when not paused. From a start pulse at cycle 0, FA is cycle 1 and the first write occurs at the end of cycle 6.
- The read issued in cycle N is consumed in cycle N+1. The sequencer never inserts an idle cycle between FA and WB.
- `pause` is sampled only in FA. Raising it in FB..WB has no effect until the next FA.
- `rst` mid-instruction, including in WB: no write is committed in the reset cycle, and the state is IDLE on the next cycle.
- `start` and `rst` in the same cycle: `rst` wins.
- `start` while `busy`: ignored.

## Test plan
- Reset: assert `rst` for 2 cycles → all outputs at their reset values and state IDLE; with `start` held low, no `mem_re` for 10 cycles.
- No branch: `mem[0..2] = 5, 6, 9`; `mem[5] = 3`; `mem[6] = 10`; pulse `start` → in cycle 6, `mem_we = 1`, `mem_addr = 6`, `mem_wdata = 7`; then `pc = 3`, `instr_count = 1`.
- Branch taken: same program with `mem[5] = 10` → write `mem[6] = 0`, `pc = 9`.
- Halt: `mem[0..2] = 5, 6, 0xFFFFFFFFFFFFFFFF`; `mem[5] = 4`; `mem[6] = 1` → write `mem[6] = 0xFFFFFFFFFFFFFFFD`, then `halted = 1`, `busy = 0`, `pc = 0`, `instr_count = 1`, no further memory traffic; a later `start` restarts at `RESET_PC`.
- Wrap: `mem[A] = 1`, `mem[B] = 0x8000000000000000` → write `0x7FFFFFFFFFFFFFFF`, no branch, `pc = 3`.
- Reset in WB and pause: assert `rst` in cycle 6 → no write, `mem[6]` unchanged, IDLE. Separately, hold `pause` at FA for 4 cycles → `mem_re = 0` throughout, and execution resumes 1 cycle after `pause` falls.
